codificador_hamming_tx: RTL



---
 rtl/codificador_hamming_tx.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/codificador_hamming_tx.sv
// ---------------------------------------------------------------------------
// codificador_hamming_tx
//
// Transmit side of the SECDED Hamming(8,4) serial link. When a start request
// is accepted while idle, the 4-bit nibble is encoded into an 8-bit codeword
// whose layout matches the receive-side corrector. An optional error mask is
// XORed in, and the result is shifted out as a UART-style frame:
// one start bit (0), eight data bits LSB first, and one stop bit (1).
// Each serial bit is held for DIV_BIT clock cycles.
//
// Codeword layout (w[7:0]):
//   w[7]=d3  w[6]=d2  w[5]=d1  w[3]=d0
//   w[1]=d0^d1^d3  w[2]=d0^d2^d3  w[4]=d1^d2^d3
//   w[0]=^w[7:1]   (even parity over the whole word)
//
// Parameters:
//   DIV_BIT             clock cycles per serial bit (>= 1)
//
// Ports:
//   reloj               system clock, all state updates on the rising edge
//   rst_n               asynchronous active-low reset
//   dato[3:0]           data nibble, sampled only when a request is accepted
//   enviar              start request, level-sampled, accepted only when idle
//   mascara_error[7:0]  error-injection mask XORed into the codeword
//   palabra_codificada  registered transmitted word, held until next accept
//   tx_serie            serial line, idle high
//   ocupado             high from acceptance through the last stop-bit cycle
//   listo               one-cycle pulse in the first idle cycle after a frame
// ---------------------------------------------------------------------------
module codificador_hamming_tx #(
    parameter int DIV_BIT = 4
) (
    input  logic       reloj,
    input  logic       rst_n,
    input  logic [3:0] dato,
    input  logic       enviar,
    input  logic [7:0] mascara_error,
    output logic [7:0] palabra_codificada,
    output logic       tx_serie,
    output logic       ocupado,
    output logic       listo
);

    // $clog2(1) is zero, so the counter keeps at least one bit for DIV_BIT=1.
    localparam int CW = (DIV_BIT > 1) ? $clog2(DIV_BIT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV_BIT - 1);

    typedef enum logic [1:0] {
        REPOSO,
        INICIO,
        DATOS,
        PARADA
    } estado_t;

    estado_t        estado_q, estado_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2:0]     bit_q, bit_d;
    logic [7:0]     shift_q, shift_d;
    logic [7:0]     palabra_q, palabra_d;
    logic           tx_q, tx_d;
    logic           ocupado_q, ocupado_d;
    logic           listo_q, listo_d;

    logic [7:0]     codigo;
    logic           fin_bit;

    // Hamming(8,4) encoder. The overall parity bit is built from the
    // already-computed upper seven bits so the full word has even parity.
    always_comb begin
        codigo    = 8'h00;
        codigo[3] = dato[0];
        codigo[5] = dato[1];
        codigo[6] = dato[2];
        codigo[7] = dato[3];
        codigo[1] = dato[0] ^ dato[1] ^ dato[3];
        codigo[2] = dato[0] ^ dato[2] ^ dato[3];
        codigo[4] = dato[1] ^ dato[2] ^ dato[3];
        codigo[0] = ^codigo[7:1];
    end

    assign fin_bit = (cnt_q == CNT_MAX);

    // Next-state logic. Outputs are derived from the next state so that
    // they can be registered and still change on the same edge as the state:
    // the start bit appears on the acceptance edge and listo rises on the
    // edge that returns to REPOSO.
    always_comb begin
        estado_d  = estado_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        palabra_d = palabra_q;
        listo_d   = 1'b0;

        unique case (estado_q)
            REPOSO: begin
                if (enviar) begin
                    palabra_d = codigo ^ mascara_error;
                    shift_d   = codigo ^ mascara_error;
                    cnt_d     = '0;
                    bit_d     = 3'd0;
                    estado_d  = INICIO;
                end
            end

            INICIO: begin
                if (fin_bit) begin
                    cnt_d    = '0;
                    estado_d = DATOS;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DATOS: begin
                if (fin_bit) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        bit_d    = 3'd0;
                        estado_d = PARADA;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            PARADA: begin
                if (fin_bit) begin
                    cnt_d    = '0;
                    listo_d  = 1'b1;
                    estado_d = REPOSO;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                estado_d = REPOSO;
                cnt_d    = '0;
                bit_d    = 3'd0;
            end
        endcase
    end

    // Serial line and busy flag for the upcoming cycle. In DATOS the line
    // follows the LSB of the shift register as it will be after this edge,
    // so the first data bit is emitted on the edge that leaves INICIO.
    always_comb begin
        tx_d      = 1'b1;
        ocupado_d = (estado_d != REPOSO);
        unique case (estado_d)
            REPOSO:  tx_d = 1'b1;
            INICIO:  tx_d = 1'b0;
            DATOS:   tx_d = shift_d[0];
            PARADA:  tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

    // State and output registers. An asynchronous reset abandons any frame
    // in progress and forces the line idle right away.
    always_ff @(posedge reloj or negedge rst_n) begin
        if (!rst_n) begin
            estado_q  <= REPOSO;
            cnt_q     <= '0;
            bit_q     <= 3'd0;
            shift_q   <= 8'h00;
            palabra_q <= 8'h00;
            tx_q      <= 1'b1;
            ocupado_q <= 1'b0;
            listo_q   <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            palabra_q <= palabra_d;
            tx_q      <= tx_d;
            ocupado_q <= ocupado_d;
            listo_q   <= listo_d;
        end
    end

    assign palabra_codificada = palabra_q;
    assign tx_serie           = tx_q;
    assign ocupado            = ocupado_q;
    assign listo              = listo_q;

endmodule
